sdm_mc_dac: RTL and testbench
=============================

# sdm_mc_dac

Multi-channel, run-time configurable sigma-delta DAC modulator. It is the successor to the fixed 16-bit second-order modulator on the user-project IO path. It converts CH offset-binary PCM words into CH 1-bit pulse-density streams. Added over the previous generation: selectable 1st/2nd order, a programmable oversampling tick, a valid/ready sample handshake, saturating integrators with sticky overflow flags, and optional LFSR dither.

## Interface
- W, 16: input sample width (unsigned offset-binary)
- CH, 2: channel count
- GUARD, 6: integrator guard bits; internal signed width IW = W+GUARD
- DIV_W, 8: prescaler divisor width
- clk  in  1  sole clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  modulator run enable
- order_sel  in  1  0 = 1st order, 1 = 2nd order
- dither_en  in  1  add LFSR dither at the quantiser
- div  in  DIV_W  modulator update period = div+1 clk cycles
- din  in  CH*W  channel c at din[c*W +: W]
- din_valid  in  1  din holds a new sample set
- din_ready  out  1  pending register empty
- ovf_clr  in  1  clear all sticky overflow flags
- dout  out  CH  1-bit modulator outputs
- ovf  out  CH  sticky integrator-saturation flags
- tick  out  1  modulator update strobe

## Operation
- Reset values: dout=0, ovf=0, din_ready=1, tick=0, cnt=0, i1=i2=0, active sample x=2^(W-1) (mid-scale), pend_full=0, lfsr=16'hACE1.
- Prescaler:
  - cnt counts 0..div. tick = en && cnt==div. On tick, cnt returns to 0.
  - div=0 gives a tick every cycle.
  - en=0 holds cnt at 0. No tick; all modulator state holds.
- Handshake:
  - din_ready = !pend_full.
  - When din_valid && din_ready, din is loaded into pend and pend_full is set.
  - On tick with pend_full, x <= pend and pend_full clears. din_ready reasserts the next cycle.
  - With no new sample, x holds. The last value is repeated indefinitely.
- Modulator step, per channel, on tick, using x, dout and the integrators as they are before the edge:
  - u = x - 2^(W-1), signed IW.
  - fb = dout ? +2^(W-1) : -2^(W-1).
  - i1' = sat(i1 + u - fb).
  - i2' = order_sel ? sat(i2 + i1' - fb) : 0.
  - q = (order_sel ? i2' : i1') + d.
  - dout' = (q >= 0).
- sat() clamps to [-2^(IW-1), 2^(IW-1)-1]. Sums are computed at IW+2 bits before the clamp.
- Any clamp event sets ovf[c]. ovf_clr clears it. A set in the same cycle as ovf_clr wins.
- Dither:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11. Advances on each tick.
  - d = dither_en ? (lfsr[3:0] - 8) : 0, range -8..7. All channels share the same d.
  - Dither is applied to the quantiser input only, never stored in an integrator.
- order_sel change takes effect at the next tick. Going 2→1 zeroes i2 at that tick.

## Timing
- dout and ovf update on the clock edge that samples tick=1. They are visible the following cycle.
- Sample latency: a sample accepted at edge E becomes x at the first tick edge after E. Its first effect on dout is at the tick edge after that, i.e. 1–2 update periods.
- Maximum sample rate is one per tick. Throughput with div=0 is one sample per 2 cycles, because of the handshake bubble.
- rst_n=0 mid-operation: all state returns to reset values on that edge, regardless of en or tick. A handshake in flight in the same cycle is discarded.

## Structure
- Package sdm_pkg:
  - LFSR seed and taps constant
  - dither offset (8)
  - function for IW
  - saturate function
- One sub-module is natural: sdm_chan, a single-channel integrator/quantiser step instantiated CH times via generate.
- The prescaler, pending register and LFSR stay in the top level and are shared.

## Test plan
- Reset, en=1, div=0, order 1, din=0x8000 held → ones count over 64 ticks = 32±1; ovf=0.
- Order 2, din=0xC000, div=0 → ones count over 256 ticks = 192±2. Repeat with dither_en=1 → 192±4.
- div=3 → tick exactly every 4th cycle. dout changes only on the cycle after tick. en=0 freezes dout and cnt at 0.
- din_valid held with 0x1000 then 0x2000 and div=7 → second word stalls (din_ready=0) until the first tick. x sequence is 0x8000→0x1000→0x2000 on consecutive ticks.
- GUARD=1, order 2, din=0xFFFF → ovf[0] sets, integrators stay clamped. ovf_clr pulse clears ovf, which re-sets if saturation persists.
- Assert rst_n=0 for one cycle mid-stream with pend_full=1 → all outputs at reset values the next cycle, din_ready=1, x=0x8000.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared constants and helpers for the multi-channel sigma-delta DAC modulator.
package sdm_pkg;

    // Dither LFSR: 16-bit Fibonacci, taps 16,14,13,11. In the right-shift form
    // used here those taps land on bits 0,2,3,5 of the register.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Dither word is lfsr[3:0] - 8, carried as a 5-bit signed value (-8..7).
    localparam int DITHER_W = 5;
    localparam logic [DITHER_W-1:0] DITHER_OFS = 5'd8;

    // Integrator width: sample width plus guard bits.
    function automatic int iw_of(input int w, input int guard);
        return w + guard;
    endfunction

    // Saturation test against a signed iw-bit range.
    // Returns {above_max, below_min}; the caller substitutes the rail value.
    function automatic logic [1:0] sat_dir(input logic signed [63:0] v, input int iw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (iw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (iw - 1));
        sat_dir = {v > hi, v < lo};
    endfunction

endpackage

// File: rtl/sdm_chan.sv
// One channel of the modulator: two saturating integrators, quantiser and
// sticky overflow flag. Advances only when step is high.
module sdm_chan
    import sdm_pkg::*;
#(
    parameter int W     = 16,
    parameter int GUARD = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step,
    input  logic                       order_sel,
    input  logic [W-1:0]               x,
    input  logic signed [DITHER_W-1:0] d,
    input  logic                       ovf_clr,
    output logic                       dout,
    output logic                       ovf
);

    localparam int IW = iw_of(W, GUARD);
    // Sums carry two extra bits so the clamp sees the true overflowed value.
    localparam int SW = IW + 2;
    localparam logic signed [SW-1:0] HALF  = {{(SW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic signed [IW-1:0] I_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] I_MIN = {1'b1, {(IW-1){1'b0}}};

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [IW-1:0] i1_n;
    logic signed [IW-1:0] i2_n;
    logic signed [IW-1:0] i2_next;
    logic signed [SW-1:0] u;
    logic signed [SW-1:0] fb;
    logic signed [SW-1:0] s1;
    logic signed [SW-1:0] s2;
    logic signed [SW-1:0] q;
    logic [1:0]           dir1;
    logic [1:0]           dir2;
    logic                 dout_n;
    logic                 clip;

    // Next integrator values, quantiser decision and clamp detection.
    always_comb begin
        u  = $signed({{(SW-W){1'b0}}, x}) - HALF;
        fb = dout ? HALF : -HALF;

        s1   = $signed({{2{i1[IW-1]}}, i1}) + u - fb;
        dir1 = sat_dir(64'(s1), IW);
        if (dir1[1])
            i1_n = I_MAX;
        else if (dir1[0])
            i1_n = I_MIN;
        else
            i1_n = s1[IW-1:0];

        s2   = $signed({{2{i1_n[IW-1]}}, i1_n}) + $signed({{2{i2[IW-1]}}, i2}) - fb;
        dir2 = sat_dir(64'(s2), IW);
        if (dir2[1])
            i2_n = I_MAX;
        else if (dir2[0])
            i2_n = I_MIN;
        else
            i2_n = s2[IW-1:0];

        // First order keeps i2 parked at zero, so a later 1->2 switch starts clean.
        i2_next = order_sel ? i2_n : '0;

        // Dither only perturbs the decision, never the stored integrators.
        if (order_sel)
            q = $signed({{2{i2_next[IW-1]}}, i2_next}) + $signed({{(SW-DITHER_W){d[DITHER_W-1]}}, d});
        else
            q = $signed({{2{i1_n[IW-1]}}, i1_n}) + $signed({{(SW-DITHER_W){d[DITHER_W-1]}}, d});

        dout_n = ~q[SW-1];
        clip   = (|dir1) | (order_sel & (|dir2));
    end

    // Integrator/output registers; overflow set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i1   <= '0;
            i2   <= '0;
            dout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (step) begin
                i1   <= i1_n;
                i2   <= i2_next;
                dout <= dout_n;
            end
            ovf <= (ovf & ~ovf_clr) | (step & clip);
        end
    end

endmodule

// File: rtl/sdm_mc_dac.sv
// Multi-channel sigma-delta DAC modulator. Shared prescaler, sample pending
// register and dither LFSR; one sdm_chan per channel.
module sdm_mc_dac
    import sdm_pkg::*;
#(
    parameter int W     = 16,
    parameter int CH    = 2,
    parameter int GUARD = 6,
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              order_sel,
    input  logic              dither_en,
    input  logic [DIV_W-1:0]  div,
    input  logic [CH*W-1:0]   din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              ovf_clr,
    output logic [CH-1:0]     dout,
    output logic [CH-1:0]     ovf,
    output logic              tick
);

    localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

    logic [DIV_W-1:0]          cnt;
    logic [CH*W-1:0]           pend;
    logic                      pend_full;
    logic [CH*W-1:0]           x;
    logic [15:0]               lfsr;
    logic [15:0]               lfsr_next;
    logic [DITHER_W-1:0]       d_raw;
    logic signed [DITHER_W-1:0] d;

    assign tick      = en && (cnt == div);
    assign din_ready = !pend_full;

    // Dither word and next LFSR state.
    always_comb begin
        lfsr_next = {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        d_raw     = {1'b0, lfsr[3:0]} - DITHER_OFS;
        d         = dither_en ? $signed(d_raw) : '0;
    end

    // Prescaler: counts 0..div, restarts on tick, parked at 0 while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Pending register accepts a sample set; a tick moves it into the active sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend      <= '0;
            pend_full <= 1'b0;
            x         <= {CH{MID}};
            lfsr      <= LFSR_SEED;
        end else begin
            if (din_valid && !pend_full) begin
                pend      <= din;
                pend_full <= 1'b1;
            end
            if (tick) begin
                lfsr <= lfsr_next;
                if (pend_full) begin
                    x         <= pend;
                    pend_full <= 1'b0;
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_chan
        sdm_chan #(
            .W     (W),
            .GUARD (GUARD)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .step      (tick),
            .order_sel (order_sel),
            .x         (x[c*W +: W]),
            .d         (d),
            .ovf_clr   (ovf_clr),
            .dout      (dout[c]),
            .ovf       (ovf[c])
        );
    end

endmodule

// File: tb/tb_sdm_mc_dac.sv
// Bench for sdm_mc_dac: two instances (GUARD=6 and GUARD=1) driven in parallel
// and compared every cycle against an arithmetic model of the modulator.
module tb_sdm_mc_dac;

    localparam int W     = 16;
    localparam int CH    = 2;
    localparam int DIV_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              en;
    logic              order_sel;
    logic              dither_en;
    logic [DIV_W-1:0]  div;
    logic [CH*W-1:0]   din;
    logic              din_valid;
    logic              ovf_clr;
    logic              din_ready0, din_ready1;
    logic              tick0, tick1;
    logic [CH-1:0]     dout0, dout1, ovf0, ovf1;

    sdm_mc_dac #(.W(W), .CH(CH), .GUARD(6), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .order_sel(order_sel), .dither_en(dither_en),
        .div(div), .din(din), .din_valid(din_valid), .din_ready(din_ready0),
        .ovf_clr(ovf_clr), .dout(dout0), .ovf(ovf0), .tick(tick0));

    sdm_mc_dac #(.W(W), .CH(CH), .GUARD(1), .DIV_W(DIV_W)) dut_g1 (
        .clk(clk), .rst_n(rst_n), .en(en), .order_sel(order_sel), .dither_en(dither_en),
        .div(div), .din(din), .din_valid(din_valid), .din_ready(din_ready1),
        .ovf_clr(ovf_clr), .dout(dout1), .ovf(ovf1), .tick(tick1));

    // Reference model state: index k = instance (0: IW=22, 1: IW=17)
    longint     m_i1 [2][CH];
    longint     m_i2 [2][CH];
    bit         m_dout [2][CH];
    bit         m_ovf [2][CH];
    int         m_x [CH];
    int         m_pend [CH];
    bit         m_pend_full;
    bit [7:0]   m_cnt;
    bit [15:0]  m_lfsr;
    int         iw_k [2] = '{22, 17};
    int         taps [4] = '{16, 14, 13, 11};

    int         n_cmp = 0;
    int         n_err = 0;
    logic [CH-1:0] prev_dout0;
    logic       tk_at_edge, rst_at_edge;
    int         ones, nt, n_low;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint msat(input longint v, input int iw, output bit clip);
        longint hi, lo;
        hi = (longint'(1) <<< (iw - 1)) - 1;
        lo = -(longint'(1) <<< (iw - 1));
        clip = 1'b0;
        if (v > hi) begin clip = 1'b1; return hi; end
        if (v < lo) begin clip = 1'b1; return lo; end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++) begin
                m_i1[k][c] = 0; m_i2[k][c] = 0; m_dout[k][c] = 0; m_ovf[k][c] = 0;
            end
        for (int c = 0; c < CH; c++) begin m_x[c] = 32768; m_pend[c] = 0; end
        m_pend_full = 0;
        m_cnt = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_edge();
        bit ld, tk, c1, c2, fbit;
        int dth;
        longint u, fbv, n1, n2, q;
        bit setf [2][CH];
        if (!rst_n) begin
            model_reset();
            return;
        end
        ld = din_valid && !m_pend_full;
        tk = en && (m_cnt == div);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++) setf[k][c] = 0;
        if (tk) begin
            dth = dither_en ? int'(m_lfsr[3:0]) - 8 : 0;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < CH; c++) begin
                    u   = m_x[c] - 32768;
                    fbv = m_dout[k][c] ? 32768 : -32768;
                    n1  = msat(m_i1[k][c] + u - fbv, iw_k[k], c1);
                    c2  = 0;
                    n2  = 0;
                    if (order_sel) n2 = msat(m_i2[k][c] + n1 - fbv, iw_k[k], c2);
                    q = (order_sel ? n2 : n1) + dth;
                    m_i1[k][c]   = n1;
                    m_i2[k][c]   = n2;
                    m_dout[k][c] = (q >= 0);
                    setf[k][c]   = c1 | c2;
                end
            fbit = 0;
            foreach (taps[t]) fbit ^= m_lfsr[16 - taps[t]];
            m_lfsr = {fbit, m_lfsr[15:1]};
            if (m_pend_full) begin
                for (int c = 0; c < CH; c++) m_x[c] = m_pend[c];
                m_pend_full = 0;
            end
        end
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++)
                m_ovf[k][c] = (m_ovf[k][c] && !ovf_clr) || setf[k][c];
        if (ld) begin
            for (int c = 0; c < CH; c++) m_pend[c] = int'(din[c*W +: W]);
            m_pend_full = 1;
        end
        m_cnt = (!en || tk) ? 8'd0 : m_cnt + 8'd1;
    endtask

    function automatic logic [CH-1:0] mdout(input int k);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_dout[k][c];
        return v;
    endfunction

    function automatic logic [CH-1:0] movf(input int k);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_ovf[k][c];
        return v;
    endfunction

    // One clock: check tick before the edge, advance the model, check state after it.
    task automatic cyc();
        #1;
        chk_eq("tick0", tick0, en && (m_cnt == div));
        chk_eq("tick1", tick1, en && (m_cnt == div));
        tk_at_edge  = tick0;
        rst_at_edge = rst_n;
        prev_dout0  = dout0;
        @(posedge clk);
        model_edge();
        #1;
        chk_eq("dout0", dout0, mdout(0));
        chk_eq("ovf0", ovf0, movf(0));
        chk_eq("ready0", din_ready0, !m_pend_full);
        chk_eq("dout1", dout1, mdout(1));
        chk_eq("ovf1", ovf1, movf(1));
        chk_eq("ready1", din_ready1, !m_pend_full);
        if (rst_at_edge && dout0 !== prev_dout0)
            chk_eq("dout_only_after_tick", tk_at_edge, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b0;
        ovf_clr = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; en = 1'b0; order_sel = 1'b0; dither_en = 1'b0; div = '0;
        din = {2{16'h8000}}; din_valid = 1'b0; ovf_clr = 1'b0;
        repeat (3) cyc();
        chk_eq("rst_dout", dout0, 2'b00);
        chk_eq("rst_ovf", ovf0, 2'b00);
        chk_eq("rst_ready", din_ready0, 1'b1);
        chk_eq("rst_tick", tick0, 1'b0);

        // First order, mid-scale: half density
        rst_n = 1'b1; en = 1'b1; din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        ones = 0;
        repeat (64) begin cyc(); ones += int'(dout0[0]); end
        chk_eq("o1_mid_ones_in_32pm1", (ones >= 31 && ones <= 33), 1'b1);
        chk_eq("o1_mid_ovf", ovf0, 2'b00);

        // Second order, 0xC000: three-quarter density, without and with dither
        for (int dz = 0; dz < 2; dz++) begin
            do_reset();
            order_sel = 1'b1; dither_en = (dz == 1);
            din = {16'($urandom), 16'hC000}; din_valid = 1'b1;
            cyc();
            din_valid = 1'b0;
            cyc();
            ones = 0;
            repeat (256) begin cyc(); ones += int'(dout0[0]); end
            if (dz == 0) chk_eq("o2_c000_ones_192pm2", (ones >= 190 && ones <= 194), 1'b1);
            else         chk_eq("o2_c000_dith_ones_192pm4", (ones >= 188 && ones <= 196), 1'b1);
        end

        // div=3: tick every 4th cycle, then en=0 freezes everything
        do_reset();
        dither_en = 1'b0; order_sel = 1'b0; div = 8'd3;
        nt = 0;
        for (int i = 0; i < 200; i++) begin
            din = $urandom; din_valid = ($urandom_range(0, 1) == 1);
            cyc();
            nt += int'(tk_at_edge);
        end
        chk_eq("div3_tick_count", nt, 50);
        en = 1'b0; din_valid = 1'b0;
        nt = 0;
        repeat (20) begin cyc(); nt += int'(tk_at_edge); end
        chk_eq("en0_no_tick", nt, 0);
        en = 1'b1;

        // Handshake stall with div=7: second word waits for the first tick
        do_reset();
        div = 8'd7; din = {2{16'h1000}}; din_valid = 1'b1;
        cyc();
        din = {2{16'h2000}};
        n_low = int'(!din_ready0);
        repeat (7) begin cyc(); n_low += int'(!din_ready0); end
        chk_eq("hs_stall_cycles", n_low, 7);
        cyc();
        chk_eq("hs_second_accepted", din_ready0, 1'b0);
        din_valid = 1'b0;
        repeat (24) cyc();

        // Saturation on the GUARD=1 instance, clear and re-set
        do_reset();
        order_sel = 1'b1; div = 8'd0; din = {2{16'hFFFF}}; din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        repeat (20) cyc();
        chk_eq("g1_ovf_set", ovf1[0], 1'b1);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        repeat (10) cyc();

        // Reset mid-stream with a pending sample and a handshake in flight
        do_reset();
        order_sel = 1'b0; div = 8'd7; din = $urandom; din_valid = 1'b1;
        repeat (5) cyc();
        chk_eq("mid_pend_full", din_ready0, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; din_valid = 1'b0;
        chk_eq("mid_rst_dout", dout0, 2'b00);
        chk_eq("mid_rst_ovf", ovf0, 2'b00);
        chk_eq("mid_rst_ready", din_ready0, 1'b1);
        repeat (40) cyc();

        // Randomized mix of everything
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            en = ($urandom_range(0, 15) != 0);
            if (i % 250 == 0) div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) order_sel = ~order_sel;
            if ($urandom_range(0, 199) == 0) dither_en = ~dither_en;
            din_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: din = {2{16'hFFFF}};
                1: din = {2{16'h0000}};
                default: din = $urandom;
            endcase
            ovf_clr = ($urandom_range(0, 31) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
